// File: rtl/stream_mux_arb_if.sv
// stream_mux_arb_if: bundle of the multiplexer's stream signals.
//   in_valid/in_data/in_last : N_CH producer streams (channel i data at [i*W +: W])
//   in_ready                 : per-channel accept, at most one bit high
//   out_valid/out_data/out_last/out_ch : registered output beat and its source channel
//   out_ready                : downstream accept
// Modports: slave = the multiplexer, master = the producer/consumer side.
interface stream_mux_arb_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  localparam int CW = $clog2(N_CH);

  logic [N_CH-1:0]   in_valid;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_last;
  logic [N_CH-1:0]   in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_last;
  logic [CW-1:0]     out_ch;
  logic              out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch
  );
endinterface

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N_CH-channel packet multiplexer with fixed-priority or
// round-robin arbitration, grant held for a whole packet, and a one-entry
// registered output stage.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stream_mux_arb_if.slave (input streams, output beat, handshakes)
//
// state   | meaning
// ST_ARB  | no packet in progress, grant chosen by the arbiter each cycle
// ST_LOCK | packet in progress on lock_ch_q, other channels blocked
module stream_mux_arb #(
  parameter int N_CH     = 4,
  parameter int W        = 8,
  parameter int ARB_MODE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_mux_arb_if.slave bus
);
  localparam int            CW      = $clog2(N_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] lock_ch_q, lock_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic [CW-1:0] out_ch_q, out_ch_d;

  logic [CW-1:0] lo_idx, hi_idx, grant, sel_ch;
  logic          found_hi, any_valid;
  logic          sel_valid, sel_last;
  logic [W-1:0]  sel_data;
  logic          buf_free, xfer;

  function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] c);
    return (c == LAST_CH) ? '0 : c + 1'b1;
  endfunction

  // Descending scan: the last hit is the lowest index overall (lo_idx) and
  // the lowest index at or above rr_ptr (hi_idx). The round-robin wrap is
  // "hi if any, else lo", which avoids a modulo in the search.
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    found_hi = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        lo_idx = CW'(i);
        if (CW'(i) >= rr_ptr_q) begin
          hi_idx   = CW'(i);
          found_hi = 1'b1;
        end
      end
    end
    any_valid = |bus.in_valid;
    if (ARB_MODE == 0) grant = lo_idx;
    else               grant = found_hi ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_ch    = (state_q == ST_LOCK) ? lock_ch_q : grant;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (CW'(i) == sel_ch) begin
        sel_valid = bus.in_valid[i];
        sel_last  = bus.in_last[i];
        sel_data  = bus.in_data[i*W +: W];
      end
    end
    buf_free = !out_valid_q || bus.out_ready;
    // In ST_ARB sel_valid implies the granted channel is valid.
    xfer     = rst_n && buf_free && sel_valid;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= '0;
      lock_ch_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_ch_q   <= lock_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_ch_d   = lock_ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;

    case (state_q)
      ST_ARB: begin
        if (xfer) begin
          if (sel_last) begin
            rr_ptr_d = next_ch(grant);
          end else begin
            state_d   = ST_LOCK;
            lock_ch_d = grant;
          end
        end
      end
      ST_LOCK: begin
        if (xfer && sel_last) begin
          state_d  = ST_ARB;
          rr_ptr_d = next_ch(lock_ch_q);
        end
      end
      default: state_d = ST_ARB;
    endcase

    // A new beat takes priority over draining; together they keep out_valid high.
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_ch_d    = sel_ch;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Outputs. In ST_LOCK the locked channel is offered ready even when its
  // valid is low, so a gap does not change the grant. Held low during reset.
  always_comb begin
    bus.in_ready = '0;
    if (rst_n && buf_free && (state_q == ST_LOCK || any_valid)) begin
      for (int i = 0; i < N_CH; i++) begin
        if (CW'(i) == sel_ch) bus.in_ready[i] = 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: drives a round-robin and a fixed-priority instance with
// identical stimulus and compares both against a behavioural model kept here.
module tb_stream_mux_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]   vin;
  logic [N*W-1:0] din;
  logic [N-1:0]   lin;
  logic           ordy;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // model state, index 0 = fixed priority, 1 = round-robin
  bit         m_lock [2];
  int         m_ch   [2];
  int         m_rr   [2];
  bit         m_ov   [2];
  logic [7:0] m_od   [2];
  bit         m_ol   [2];
  int         m_oc   [2];

  always #5 clk = ~clk;

  stream_mux_arb_if #(.N_CH(N), .W(W)) if_rr ();
  stream_mux_arb_if #(.N_CH(N), .W(W)) if_fp ();

  assign if_rr.in_valid  = vin;
  assign if_rr.in_data   = din;
  assign if_rr.in_last   = lin;
  assign if_rr.out_ready = ordy;
  assign if_fp.in_valid  = vin;
  assign if_fp.in_data   = din;
  assign if_fp.in_last   = lin;
  assign if_fp.out_ready = ordy;

  stream_mux_arb #(.N_CH(N), .W(W), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(if_rr.slave));
  stream_mux_arb #(.N_CH(N), .W(W), .ARB_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(if_fp.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_lock[m] = 0; m_ch[m] = 0; m_rr[m] = 0;
      m_ov[m] = 0; m_od[m] = '0; m_ol[m] = 0; m_oc[m] = 0;
    end
  endfunction

  // Channel owning the cycle, or -1 when nobody is offered ready.
  function automatic int pick(input int m);
    if (m_lock[m]) return m_ch[m];
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m == 1) ? (m_rr[m] + k) % N : k;
      if (vin[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_beat(input int ch, input logic [7:0] d, input bit l);
    din[ch*W +: W] = d;
    lin[ch] = l;
  endtask

  task automatic chk_out(input int m);
    string p;
    p = (m == 1) ? "rr" : "fp";
    chk({p, "_out_valid"}, (m == 1) ? if_rr.out_valid : if_fp.out_valid, m_ov[m]);
    chk({p, "_out_data"},  (m == 1) ? if_rr.out_data  : if_fp.out_data,  m_od[m]);
    chk({p, "_out_last"},  (m == 1) ? if_rr.out_last  : if_fp.out_last,  m_ol[m]);
    chk({p, "_out_ch"},    (m == 1) ? if_rr.out_ch    : if_fp.out_ch,    m_oc[m]);
  endtask

  // Called just after a falling edge with inputs already set; returns at the next falling edge.
  task automatic cycle();
    int       gc [2];
    bit       xf [2];
    bit       bf;
    logic [N-1:0] er;
    #1;
    for (int m = 0; m < 2; m++) begin
      gc[m] = pick(m);
      bf = !m_ov[m] || ordy;
      er = '0;
      if (gc[m] >= 0 && bf) er[gc[m]] = 1'b1;
      chk((m == 1) ? "rr_in_ready" : "fp_in_ready",
          (m == 1) ? if_rr.in_ready : if_fp.in_ready, er);
      xf[m] = (gc[m] >= 0) && bf && vin[gc[m]];
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (xf[m]) begin
        m_ov[m] = 1;
        m_od[m] = din[gc[m]*W +: W];
        m_ol[m] = lin[gc[m]];
        m_oc[m] = gc[m];
        if (lin[gc[m]]) begin
          m_lock[m] = 0;
          m_rr[m] = (gc[m] + 1) % N;
        end else begin
          m_lock[m] = 1;
          m_ch[m] = gc[m];
        end
      end else if (m_ov[m] && ordy) begin
        m_ov[m] = 0;
      end
    end
    #1;
    chk_out(0);
    chk_out(1);
    @(negedge clk);
  endtask

  initial begin
    // reset with every channel offering
    rst_n = 1'b0; vin = '1; din = '0; lin = '0; ordy = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_rr_in_ready", if_rr.in_ready, 0);
    chk("rst_fp_in_ready", if_fp.in_ready, 0);
    chk("rst_rr_out_valid", if_rr.out_valid, 0);
    chk("rst_rr_out_data", if_rr.out_data, 0);
    chk("rst_rr_out_last", if_rr.out_last, 0);
    chk("rst_rr_out_ch", if_rr.out_ch, 0);
    chk("rst_fp_out_valid", if_fp.out_valid, 0);
    vin = '0;
    rst_n = 1'b1;

    // single 3-beat packet on ch2
    for (int b = 0; b < 3; b++) begin
      vin = 4'b0100;
      set_beat(2, 8'(8'h11 * (b + 1)), b == 2);
      cycle();
      chk("single_data", if_rr.out_data, 8'h11 * (b + 1));
      chk("single_ch", if_rr.out_ch, 2);
      chk("single_last", if_rr.out_last, (b == 2) ? 1 : 0);
    end
    vin = '0;
    cycle();

    // all channels stream single-beat packets; rr resumes after ch2
    vin = '1; lin = '1;
    for (int c = 0; c < N; c++) din[c*W +: W] = 8'(8'hA0 + c);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_order", if_rr.out_ch, (3 + k) % N);
      chk("rr_data", if_rr.out_data, 8'hA0 + (3 + k) % N);
      chk("fp_only_ch0", if_fp.out_ch, 0);
    end
    vin = 4'b1110;
    cycle();
    chk("fp_next_ch1", if_fp.out_ch, 1);
    vin = '0;
    cycle();

    // packet lock with a 3-cycle gap while ch0 waits
    lin = '0;
    vin = 4'b0010; set_beat(1, 8'h51, 0);
    cycle();
    chk("lock_first", if_rr.out_data, 8'h51);
    vin = 4'b0001; set_beat(0, 8'h50, 1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("gap_rr_ready0", if_rr.in_ready[0], 0);
      chk("gap_fp_ready0", if_fp.in_ready[0], 0);
      cycle();
    end
    vin = 4'b0011; set_beat(1, 8'h52, 1);
    cycle();
    chk("lock_second_rr", if_rr.out_data, 8'h52);
    chk("lock_second_fp", if_fp.out_ch, 1);
    vin = 4'b0001;
    cycle();
    chk("after_lock_rr", if_rr.out_ch, 0);
    chk("after_lock_fp", if_fp.out_data, 8'h50);

    // backpressure on a buffered beat
    vin = 4'b0100; set_beat(2, 8'h61, 0);
    cycle();
    ordy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_beat(2, 8'(8'h63 + k), 0);
      #1;
      chk("bp_rr_ready", if_rr.in_ready, 0);
      cycle();
      chk("bp_hold_data", if_rr.out_data, 8'h61);
      chk("bp_hold_valid", if_rr.out_valid, 1);
    end
    ordy = 1'b1; set_beat(2, 8'h62, 1);
    cycle();
    chk("bp_reload_data", if_rr.out_data, 8'h62);
    chk("bp_reload_last", if_rr.out_last, 1);
    vin = '0;
    cycle();

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      vin  = N'($urandom_range(0, 15));
      din  = $urandom;
      for (int c = 0; c < N; c++) lin[c] = ($urandom_range(0, 2) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // clean reset, then reset in the middle of a ch3 packet
    vin = '0; ordy = 1'b1; rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    vin = 4'b1000; lin = '0; set_beat(3, 8'h81, 0);
    cycle();
    chk("mid_beat1", if_rr.out_data, 8'h81);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rr_valid", if_rr.out_valid, 0);
    chk("mid_rst_fp_valid", if_fp.out_valid, 0);
    chk("mid_rst_rr_ready", if_rr.in_ready, 0);
    chk("mid_rst_fp_ready", if_fp.in_ready, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    vin = 4'b1001; lin = 4'b1001; set_beat(0, 8'h70, 1); set_beat(3, 8'h83, 1);
    cycle();
    chk("post_rst_rr_ch", if_rr.out_ch, 0);
    chk("post_rst_rr_data", if_rr.out_data, 8'h70);
    chk("post_rst_fp_ch", if_fp.out_ch, 0);
    cycle();
    chk("post_rst_rr_next", if_rr.out_ch, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel streaming multiplexer: the sequential successor of the team's fixed 4:1 data muxes. It arbitrates between `N_CH` valid/ready input streams, holds the grant for a whole packet (until `last`), and forwards beats through a one-entry registered output stage. It sits between multiple packet producers and a single downstream consumer.

## Interface
- `N_CH`, default 4: number of input channels, legal range 2..16.
- `W`, default 8: data width per channel, ≥1.
- `ARB_MODE`, default 1: arbitration mode. 0 = fixed priority, channel 0 highest. 1 = round-robin.
- `CW`, derived, not overridable: `$clog2(N_CH)`.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input N_CH: per-channel beat valid.
- `in_data` input N_CH*W: channel i occupies `[i*W +: W]`.
- `in_last` input N_CH: per-channel end-of-packet flag.
- `in_ready` output N_CH: per-channel accept. At most one bit is high in any cycle.
- `out_valid` output 1: registered output beat valid.
- `out_data` output W: registered beat data.
- `out_last` output 1: registered end-of-packet flag.
- `out_ch` output CW: source channel of the current output beat.
- `out_ready` input 1: downstream accept.

## Operation
**Transfer rules**
- An input transfer occurs on channel i when `in_valid[i] && in_ready[i]`.
- An output transfer occurs when `out_valid && out_ready`.

**Output stage**
- The output stage is a single register entry.
- `buf_free = !out_valid || out_ready`. This is a combinational path from `out_ready` to `in_ready` and is permitted.

**States**
- ARB: no packet in progress.
  - grant = selected channel among those with `in_valid` set.
  - Fixed-priority mode (`ARB_MODE` = 0): selected channel is the lowest index.
  - Round-robin mode (`ARB_MODE` = 1): selected channel is the first valid index at or after `rr_ptr`, searching upward modulo N_CH.
  - `in_ready[grant] = buf_free`. All other bits are 0. If no input is valid, all bits are 0.
- LOCK: a packet is in progress.
  - grant = `lock_ch`.
  - `in_ready[lock_ch] = buf_free`. All other bits are 0.

**Transitions**
- ARB → LOCK: a transfer is accepted with `in_last` = 0. Set `lock_ch` = grant.
- ARB → ARB: a transfer is accepted with `in_last` = 1 (single-beat packet). Set `rr_ptr` = (grant+1) mod N_CH.
- LOCK → ARB: a transfer is accepted with `in_last` = 1. Set `rr_ptr` = (`lock_ch`+1) mod N_CH.
- LOCK holds if `in_valid[lock_ch]` drops mid-packet. Gaps are legal; other channels stay blocked.
- `rr_ptr` changes only at packet end. In fixed-priority mode `rr_ptr` is unused.

**Output register update**
- On an input transfer: load `out_data` = selected channel's data, `out_last`, `out_ch` = grant, and set `out_valid` = 1.
- Else on an output transfer: `out_valid` = 0. `out_data`, `out_last` and `out_ch` hold their values.
- Input and output transfer in the same cycle: the new beat replaces the old one and `out_valid` stays 1.
- While `out_valid` = 1 and `out_ready` = 0, all output registers are stable.

**Invariants**
- Beats from different packets never interleave.
- Beat order within a channel is preserved.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_ch` = 0.
  - State = ARB, `rr_ptr` = 0, `lock_ch` = 0.
  - `in_ready` = 0 while `rst_n` is low.
- Reset deasserts synchronously to `clk` at the module boundary, so the first accept is possible on the first edge after release.
- Reset mid-packet discards the partial packet and the buffered beat. No recovery is attempted.
- Latency: a beat accepted on edge k appears on `out_*` immediately after edge k, i.e. one cycle, registered.
- Throughput: 1 beat per cycle while the source streams and `out_ready` = 1.
- Arbitration adds no bubble. A new packet's first beat can be accepted on the cycle after the previous `last` beat was accepted.
- `in_ready` is a combinational function of state, `rr_ptr`, `in_valid`, `out_valid` and `out_ready`. It has no dependence on `in_data` or `in_last`.

## Test plan
- **Single channel stream:** N_CH=4, W=8, RR mode. Ch2 sends a 3-beat packet 0x11, 0x22, 0x33 (last on 0x33) with `out_ready`=1.
  - Required: `out_data` 0x11/0x22/0x33 on three consecutive cycles, each one cycle after accept.
  - `out_ch`=2, `out_last` only on 0x33, `rr_ptr`→3.
- **Round-robin fairness:** all four channels continuously offer 1-beat packets (data = 0xA0+ch) from reset.
  - Required: output order ch0, ch1, ch2, ch3, ch0…, one beat per cycle.
- **Fixed priority:** `ARB_MODE`=0, same stimulus as the fairness test.
  - Required: only ch0 beats appear.
  - After ch0 deasserts valid, ch1 is served.
- **Packet lock with gap:** ch1 starts a 2-beat packet and drops valid for 3 cycles mid-packet while ch0 is valid.
  - Required: `in_ready[0]`=0 throughout the gap.
  - Ch1's second beat follows, then ch0 is granted.
- **Backpressure:** `out_ready`=0 for 4 cycles while a beat is buffered.
  - Required: `out_*` stable, all `in_ready`=0.
  - On `out_ready`=1, buffered beat transfers and the next beat loads the same cycle. No loss or duplication.
- **Reset mid-packet:** assert `rst_n`=0 after beat 1 of a 3-beat packet on ch3.
  - Required: `out_valid`=0 immediately (asynchronous), `in_ready`=0.
  - After release, a new packet on ch0 is granted (state ARB, `rr_ptr`=0).
